wb_stage: RTL
=============

Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback data formatter for the P5 pipelined MIPS core.
- It is the producer that drives the register file write port (write address, write data, write PC).
- It latches the MEM-stage result, sign- or zero-extends load data, and selects ALU / load / link value.
- It suppresses writes for bubbles and stalls, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_3000, value of WPC after reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_pc  in  32  PC of the MEM instruction.
- mem_wa  in  5  destination register (0 = no write).
- mem_wsel  in  2  write source: 0 ALU, 1 load, 2 link (pc+8), 3 treated as ALU.
- mem_alu  in  32  ALU/MDU result.
- mem_rdata  in  32  raw data-memory word.
- mem_ldtype  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; others treated as LW.
- mem_addr_lo  in  2  byte offset of the load address.
- stall  in  1  hold the stage contents.
- flush  in  1  replace the incoming instruction with a bubble.
- WA  out  5  register-file write address (0 = no write).
- WD  out  32  register-file write data.
- WPC  out  32  PC of the writing instruction.
- wb_valid  out  1  stage holds a real instruction.
- retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async):
  - valid = 0, stored wa = 0, alu = 0, rdata = 0, pc = RESET_PC, retire_cnt = 0.
  - Outputs after reset: WA = 0, WD = 0, WPC = RESET_PC, wb_valid = 0.
- Register update, on each rising clk edge, in priority order:
  - flush: valid <= 0; other fields don't-care, but wa is still cleared.
  - else stall: all fields hold.
  - else: all mem_* fields are captured, with valid <= mem_valid.
  - flush wins over stall.
- Latency: one cycle from MEM inputs to WA/WD/WPC. WD is derived combinationally from registered fields only. No combinational path from mem_* to any output.
- Write gating:
  - WA = stored wa when valid = 1 and stall = 0; otherwise WA = 0.
  - A stalled instruction writes only on its final (unstalled) cycle, so there is exactly one write per instruction.
- WD selection:
  - wsel 0 or 3: alu.
  - wsel 2: pc + 8, modulo 2^32.
  - wsel 1: load data, formatted as below.
- Load formatting (b = byte selected by addr_lo; h = halfword selected by addr_lo[1] only):
  - LW: rdata.
  - LB: sign-extend b. LBU: zero-extend b.
  - LH: sign-extend h. LHU: zero-extend h.
  - addr_lo[0] is ignored for halfword loads; misalignment is not checked here.
  - Byte mapping is little-endian: addr_lo 0 selects rdata[7:0], 3 selects rdata[31:24].
- WPC = stored pc, regardless of valid.
- retire_cnt increments by 1 on a clock edge where valid = 1 and stall = 0. It wraps from all-ones to 0. Bubbles and stall cycles do not count.
- When wa = 0 and valid = 1, WA is 0 (no write) but the instruction is still counted as retired.

Optional Feature:
- Macro WB_TRACE_EN.
- When defined: at each rising edge where WA != 0, emit a simulation print of time, WPC, WA and WD in the format "time@pc: $reg <= data". The register file must then have its own print disabled to avoid duplicates.
- When undefined: no print statements; the RTL is fully synthesizable with identical port behaviour.

Decomposition:
- Shared package holds:
  - WSEL_ALU/WSEL_LOAD/WSEL_LINK encodings.
  - LD_LW/LD_LB/LD_LBU/LD_LH/LD_LHU encodings.
  - RESET_PC default constant.
- One sub-module, load_ext: purely combinational (rdata, addr_lo, ldtype) -> formatted 32-bit word. It is also reusable by the MEM-stage forwarding logic.

Test Plan:
- Reset mid-operation: assert reset with valid = 1 and wa = 8 → WA = 0, wb_valid = 0, WPC = 32'h3000 and retire_cnt = 0 immediately, without waiting for a clock edge.
- ALU write: mem_valid = 1, wa = 5, wsel = 0, alu = 32'h1234 → next cycle WA = 5, WD = 32'h1234; retire_cnt goes 0 → 1.
- Loads with rdata = 32'h80FF_7F01:
  - LB, addr_lo = 2 → WD = 32'hFFFF_FFFF.
  - LBU, addr_lo = 3 → WD = 32'h0000_0080.
  - LH, addr_lo = 1 → WD = 32'h0000_7F01.
  - LHU, addr_lo = 2 → WD = 32'h0000_80FF.
- Link: wsel = 2, pc = 32'h3010, wa = 31 → WD = 32'h3018, WA = 31.
- Stall then flush:
  - Stall held for 3 cycles on a valid wa = 4 instruction → WA = 0 during the stall, then WA = 4 for exactly one cycle, retire_cnt +1.
  - flush and stall together → wb_valid = 0 next cycle.
- Counter wrap: force retire_cnt to all-ones, retire one instruction → retire_cnt = 0. A wa = 0 instruction → WA = 0 and the count still increments.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared encodings for the MEM/WB writeback stage.
//   wsel_e    : writeback source select (ALU, load, link).
//   ldtype_e  : load width/sign encodings.
//   WB_RESET_PC : default WPC after reset.
package wb_stage_pkg;

   typedef enum logic [1:0] {
      WSEL_ALU  = 2'd0,
      WSEL_LOAD = 2'd1,
      WSEL_LINK = 2'd2
   } wsel_e;

   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } ldtype_e;

   localparam logic [31:0] WB_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/load_ext.sv
// load_ext: combinational load-data formatter (little-endian).
//   rdata   in  32  raw data-memory word
//   addr_lo in  2   byte offset; bit 0 ignored for halfwords
//   ldtype  in  3   LW/LB/LBU/LH/LHU; unknown codes behave as LW
//   data    out 32  sign/zero-extended result
module load_ext
   import wb_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  ldtype,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      data = rdata;
      case (ldtype)
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {24'd0, byte_sel};
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register and writeback formatter.
// Drives the register-file write port and counts retired instructions.
//   clk, reset            clock (rising), async active-high reset
//   mem_valid/pc/wa/wsel  MEM-stage instruction fields
//   mem_alu, mem_rdata    ALU result, raw memory word
//   mem_ldtype/addr_lo    load format and byte offset
//   stall, flush          hold stage / insert bubble (flush wins)
//   WA, WD, WPC           register-file write address/data/PC
//   wb_valid              stage holds a real instruction
//   retire_cnt            retired-instruction counter (wraps)
// Optional: define WB_TRACE_EN for a per-write simulation trace print.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = WB_RESET_PC,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_valid,
   input  logic [31:0]      mem_pc,
   input  logic [4:0]       mem_wa,
   input  logic [1:0]       mem_wsel,
   input  logic [31:0]      mem_alu,
   input  logic [31:0]      mem_rdata,
   input  logic [2:0]       mem_ldtype,
   input  logic [1:0]       mem_addr_lo,
   input  logic             stall,
   input  logic             flush,
   output logic [4:0]       WA,
   output logic [31:0]      WD,
   output logic [31:0]      WPC,
   output logic             wb_valid,
   output logic [CNT_W-1:0] retire_cnt
);

   logic             valid_q,   valid_d;
   logic [4:0]       wa_q,      wa_d;
   logic [1:0]       wsel_q,    wsel_d;
   logic [31:0]      alu_q,     alu_d;
   logic [31:0]      rdata_q,   rdata_d;
   logic [2:0]       ldtype_q,  ldtype_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   logic [31:0]      pc_q,      pc_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [31:0]      ld_data;

   always_comb begin
      valid_d   = valid_q;
      wa_d      = wa_q;
      wsel_d    = wsel_q;
      alu_d     = alu_q;
      rdata_d   = rdata_q;
      ldtype_d  = ldtype_q;
      addr_lo_d = addr_lo_q;
      pc_d      = pc_q;
      if (flush) begin
         valid_d = 1'b0;
         wa_d    = '0;
      end else if (!stall) begin
         valid_d   = mem_valid;
         wa_d      = mem_wa;
         wsel_d    = mem_wsel;
         alu_d     = mem_alu;
         rdata_d   = mem_rdata;
         ldtype_d  = mem_ldtype;
         addr_lo_d = mem_addr_lo;
         pc_d      = mem_pc;
      end
   end

   // An instruction retires on the edge that ends its unstalled cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (valid_q && !stall) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         wa_q      <= '0;
         wsel_q    <= '0;
         alu_q     <= '0;
         rdata_q   <= '0;
         ldtype_q  <= '0;
         addr_lo_q <= '0;
         pc_q      <= RESET_PC;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         wa_q      <= wa_d;
         wsel_q    <= wsel_d;
         alu_q     <= alu_d;
         rdata_q   <= rdata_d;
         ldtype_q  <= ldtype_d;
         addr_lo_q <= addr_lo_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
      end
   end

   load_ext u_load_ext (
      .rdata   (rdata_q),
      .addr_lo (addr_lo_q),
      .ldtype  (ldtype_q),
      .data    (ld_data)
   );

   always_comb begin
      WD = alu_q;
      case (wsel_q)
         WSEL_LOAD: WD = ld_data;
         WSEL_LINK: WD = pc_q + 32'd8;
         default:   WD = alu_q;
      endcase
   end

   // Gating on the live stall makes a held instruction write only once.
   assign WA         = (valid_q && !stall) ? wa_q : 5'd0;
   assign WPC        = pc_q;
   assign wb_valid   = valid_q;
   assign retire_cnt = cnt_q;

`ifdef WB_TRACE_EN
   always_ff @(posedge clk) begin
      if (WA != 5'd0)
         $display("%0t@%08h: $%0d <= %08h", $time, WPC, WA, WD);
   end
`else
`endif

endmodule
